// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of an 8N1/8N2 framer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (line low)
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | STOP_BITS stop bits; pops the next byte on the last cycle
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_AW      = 2,
    parameter int STOP_BITS    = 1
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       start,
    output logic       cereal,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int               DEPTH_I   = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH     = (FIFO_AW + 1)'(DEPTH_I);
    localparam logic [FIFO_AW:0] CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    logic [7:0]         mem [DEPTH_I];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    state_t             state_q, state_d;
    logic [15:0]        baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               cereal_q, cereal_d;
    logic               busy_q, full_q, overflow_q;
    logic               pop, push_acc, bit_end;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // A push while full is still accepted when the framer pops in the same cycle.
    assign push_acc = start && (!full_q || pop);
    assign bit_end  = (baud_q == BAUD_LAST);

    always_comb begin
        count_d = count_q;
        case ({push_acc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (push_acc) mem[wr_ptr_q] <= data;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d = ^mem[rd_ptr_q];
`endif
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_d = 16'd0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = 3'd0;
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            shift_d = mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                            parity_d = ^mem[rd_ptr_q];
`endif
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                baud_d  = 16'd0;
                bit_d   = 3'd0;
                state_d = IDLE;
            end
        endcase

        // Line level is registered from the next state so it changes on the same edge.
        case (state_d)
            START:   cereal_d = 1'b0;
            DATA:    cereal_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  cereal_d = parity_d;
`endif
            default: cereal_d = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            baud_q     <= 16'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            cereal_q   <= 1'b1;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)      rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q    <= count_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            cereal_q   <= cereal_d;
            busy_q     <= (state_d != IDLE) || (count_d != '0);
            full_q     <= (count_d == DEPTH);
            overflow_q <= start && full_q && !pop;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign cereal    = cereal_q;
    assign busy      = busy_q;
    assign fifo_full = full_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=4, FIFO_AW=2, STOP_BITS=1.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       start;
    logic       cereal, busy, fifo_full, overflow;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(2), .STOP_BITS(1)) dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .data      (data),
        .start     (start),
        .cereal    (cereal),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks one frame cycle by cycle from index 'first'; optionally pushes push_b at index push_at.
    task automatic frame(input logic [7:0] b, input int first, input int push_at, input logic [7:0] push_b);
        logic [10:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        for (int k = first; k < NBITS * CPB; k++) begin
            chk($sformatf("frame_%h_bit%0d", b, k / CPB), {7'd0, cereal}, {7'd0, bits[k / CPB]});
            chk($sformatf("frame_%h_busy", b), {7'd0, busy}, 8'd1);
            if (k == push_at) begin
                start = 1'b1;
                data  = push_b;
            end
            tick();
            if (k == push_at) start = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        data  = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_cereal", {7'd0, cereal}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_full", {7'd0, fifo_full}, 8'd0);
        chk("rst_ovf", {7'd0, overflow}, 8'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_cereal", {7'd0, cereal}, 8'd1);

        // single byte
        start = 1'b1;
        data  = 8'h41;
        tick();
        start = 1'b0;
        chk("t1_cereal_after_push", {7'd0, cereal}, 8'd1);
        chk("t1_busy_after_push", {7'd0, busy}, 8'd1);
        tick();
        frame(8'h41, 0, -1, 8'h00);
        chk("t1_busy_end", {7'd0, busy}, 8'd0);
        chk("t1_cereal_end", {7'd0, cereal}, 8'd1);
        repeat (3) tick();

        // back-to-back pushes
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            data  = (i == 0) ? 8'h48 : (i == 1) ? 8'h49 : 8'h21;
            tick();
            if (i == 1) chk("t2_first_start", {7'd0, cereal}, 8'd0);
        end
        start = 1'b0;
        frame(8'h48, 1, -1, 8'h00);
        frame(8'h49, 0, -1, 8'h00);
        frame(8'h21, 0, -1, 8'h00);
        chk("t2_busy_end", {7'd0, busy}, 8'd0);
        repeat (3) tick();

        // overflow
        for (int i = 0; i < 6; i++) begin
            start = 1'b1;
            data  = 8'h30 + 8'(i);
            tick();
            if (i == 4) chk("t3_full", {7'd0, fifo_full}, 8'd1);
            if (i < 5) chk("t3_no_ovf", {7'd0, overflow}, 8'd0);
            if (i == 5) chk("t3_ovf", {7'd0, overflow}, 8'd1);
        end
        start = 1'b0;
        tick();
        chk("t3_ovf_pulse_end", {7'd0, overflow}, 8'd0);
        chk("t3_full_held", {7'd0, fifo_full}, 8'd1);
        frame(8'h30, 5, -1, 8'h00);
        chk("t3_not_full", {7'd0, fifo_full}, 8'd0);
        for (int i = 1; i < 5; i++) frame(8'h30 + 8'(i), 0, -1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            chk("t3_dropped_idle", {6'd0, busy, cereal}, 8'd1);
            tick();
        end

        // push during pop while full
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            data  = (i == 0) ? 8'h55 : (i == 1) ? 8'hA3 : (i == 2) ? 8'h0F : (i == 3) ? 8'hF0 : 8'h81;
            tick();
        end
        start = 1'b0;
        chk("t4_full", {7'd0, fifo_full}, 8'd1);
        frame(8'h55, 3, NBITS * CPB - 1, 8'h7E);
        chk("t4_full_after", {7'd0, fifo_full}, 8'd1);
        chk("t4_no_ovf", {7'd0, overflow}, 8'd0);
        frame(8'hA3, 0, -1, 8'h00);
        frame(8'h0F, 0, -1, 8'h00);
        frame(8'hF0, 0, -1, 8'h00);
        frame(8'h81, 0, -1, 8'h00);
        frame(8'h7E, 0, -1, 8'h00);
        chk("t4_busy_end", {7'd0, busy}, 8'd0);
        repeat (3) tick();

        // reset mid-frame
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            data  = (i == 0) ? 8'h00 : 8'h5A;
            tick();
        end
        start = 1'b0;
        repeat (16) tick();
        chk("t5_in_data", {7'd0, cereal}, 8'd0);
        chk("t5_busy_pre", {7'd0, busy}, 8'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_cereal", {7'd0, cereal}, 8'd1);
        chk("t5_async_busy", {7'd0, busy}, 8'd0);
        chk("t5_async_full", {7'd0, fifo_full}, 8'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t5_quiet", {6'd0, busy, cereal}, 8'd1);
        end

        // fresh push after reset; odd-parity-count byte
        start = 1'b1;
        data  = 8'h43;
        tick();
        start = 1'b0;
        tick();
        frame(8'h43, 0, -1, 8'h00);
        chk("t6_busy_end", {7'd0, busy}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
